// File: rtl/tlul_socket_1n_dec_if.sv
// TL-UL channel pair: the master drives the A channel and D-ready, the slave drives
// A-ready and the D channel.
interface tlul_socket_1n_dec_if;
  logic        a_valid;
  logic [2:0]  a_opcode;
  logic [1:0]  a_size;
  logic [7:0]  a_source;
  logic [31:0] a_address;
  logic [3:0]  a_mask;
  logic [31:0] a_data;
  logic        a_ready;
  logic        d_valid;
  logic [2:0]  d_opcode;
  logic [1:0]  d_size;
  logic [7:0]  d_source;
  logic [31:0] d_data;
  logic        d_error;
  logic        d_ready;

  modport master (
    output a_valid, a_opcode, a_size, a_source, a_address, a_mask, a_data, d_ready,
    input  a_ready, d_valid, d_opcode, d_size, d_source, d_data, d_error
  );

  modport slave (
    input  a_valid, a_opcode, a_size, a_source, a_address, a_mask, a_data, d_ready,
    output a_ready, d_valid, d_opcode, d_size, d_source, d_data, d_error
  );
endinterface

// File: rtl/tlul_socket_1n_dec.sv
// 1:N TL-UL demux with address decode, in-order outstanding tracking and an error sink.
// Optional response timeout is enabled by defining TLUL_SOCKET_TIMEOUT_EN.
module tlul_socket_1n_dec #(
  parameter int          N          = 11,
  parameter logic [31:0] AddrSpace [N] = '{default: 32'h0},
  parameter logic [31:0] AddrMask  [N] = '{default: 32'hFFF},
  parameter int          MaxOutst   = 4,
  parameter int          TimeoutCyc = 1024
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  tlul_socket_1n_dec_if.slave  tl_h,
  tlul_socket_1n_dec_if.master tl_d [N],
  output logic                 timeout_o
);
  localparam int SelW = $clog2(N + 1);
  localparam int NS   = 1 << SelW;
  localparam int CntW = $clog2(MaxOutst + 1);
  localparam logic [SelW-1:0] SelErr = SelW'(N);
  localparam logic [CntW-1:0] CntMax = CntW'(MaxOutst);

  typedef enum logic [1:0] {IDLE, ACTIVE, ERR, TOUT} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [SelW-1:0] sel_q, sel;
  logic [7:0]      cap_source_q;
  logic [1:0]      cap_size_q;
  logic            cap_get_q;
  logic            live, fwd_ok, req_fire, dev_req_fire, sink_fire;
  logic            rsp_fire, tout_hit, tout_retire;

  // Device-side signals padded to a power of two so sel/sel_q index them directly.
  logic        dev_a_ready  [NS];
  logic        dev_d_valid  [NS];
  logic [2:0]  dev_d_opcode [NS];
  logic [1:0]  dev_d_size   [NS];
  logic [7:0]  dev_d_source [NS];
  logic [31:0] dev_d_data   [NS];
  logic        dev_d_error  [NS];

  if (N < 1 || N > 15 || MaxOutst < 1 || TimeoutCyc < 2) begin : g_param_check
    $error("tlul_socket_1n_dec: parameter out of range");
  end

  // Reset also blanks every handshake output combinationally.
  assign live = ~rst_i;

  always_comb begin
    sel = SelErr;
    for (int i = N - 1; i >= 0; i--) begin
      if ((tl_h.a_address & ~AddrMask[i]) == AddrSpace[i]) sel = SelW'(i);
    end
  end

  always_comb begin
    fwd_ok = 1'b0;
    if (state_q == IDLE || state_q == ACTIVE)
      fwd_ok = (cnt_q == '0) || (sel == sel_q && cnt_q < CntMax && sel != SelErr);
  end

  assign tl_h.a_ready = live & fwd_ok & ((sel == SelErr) ? (state_q == IDLE) : dev_a_ready[sel]);
  assign req_fire     = tl_h.a_valid & tl_h.a_ready;
  assign dev_req_fire = req_fire & (sel != SelErr);
  assign sink_fire    = req_fire & (sel == SelErr);
  assign rsp_fire     = live & (state_q == ACTIVE) & dev_d_valid[sel_q] & tl_h.d_ready;
  assign tout_retire  = live & (state_q == TOUT) & tl_h.d_ready;

  always_comb begin
    tl_h.d_valid  = 1'b0;
    tl_h.d_opcode = 3'd0;
    tl_h.d_size   = 2'd0;
    tl_h.d_source = 8'd0;
    tl_h.d_data   = 32'd0;
    tl_h.d_error  = 1'b0;
    if (live && (state_q == ERR || state_q == TOUT)) begin
      tl_h.d_valid  = 1'b1;
      tl_h.d_opcode = cap_get_q ? 3'd1 : 3'd0;
      tl_h.d_size   = cap_size_q;
      tl_h.d_source = cap_source_q;
      tl_h.d_data   = 32'hFFFF_FFFF;
      tl_h.d_error  = 1'b1;
    end else if (live && state_q == ACTIVE) begin
      tl_h.d_valid  = dev_d_valid[sel_q];
      tl_h.d_opcode = dev_d_opcode[sel_q];
      tl_h.d_size   = dev_d_size[sel_q];
      tl_h.d_source = dev_d_source[sel_q];
      tl_h.d_data   = dev_d_data[sel_q];
      tl_h.d_error  = dev_d_error[sel_q];
    end
  end

  for (genvar gi = 0; gi < NS; gi++) begin : g_dev
    if (gi < N) begin : g_port
      logic hit;
      assign hit                = live & fwd_ok & (sel == SelW'(gi));
      assign tl_d[gi].a_valid   = hit & tl_h.a_valid;
      assign tl_d[gi].a_opcode  = hit ? tl_h.a_opcode  : 3'd0;
      assign tl_d[gi].a_size    = hit ? tl_h.a_size    : 2'd0;
      assign tl_d[gi].a_source  = hit ? tl_h.a_source  : 8'd0;
      assign tl_d[gi].a_address = hit ? tl_h.a_address : 32'd0;
      assign tl_d[gi].a_mask    = hit ? tl_h.a_mask    : 4'd0;
      assign tl_d[gi].a_data    = hit ? tl_h.a_data    : 32'd0;
      // With nothing outstanding, any device response is stale and is drained silently.
      assign tl_d[gi].d_ready   = live & ((state_q == ACTIVE)
                                  ? (sel_q == SelW'(gi)) & tl_h.d_ready
                                  : (cnt_q == '0) & (state_q != TOUT) & tl_d[gi].d_valid);
      assign dev_a_ready[gi]  = tl_d[gi].a_ready;
      assign dev_d_valid[gi]  = tl_d[gi].d_valid;
      assign dev_d_opcode[gi] = tl_d[gi].d_opcode;
      assign dev_d_size[gi]   = tl_d[gi].d_size;
      assign dev_d_source[gi] = tl_d[gi].d_source;
      assign dev_d_data[gi]   = tl_d[gi].d_data;
      assign dev_d_error[gi]  = tl_d[gi].d_error;
    end else begin : g_pad
      assign dev_a_ready[gi]  = 1'b0;
      assign dev_d_valid[gi]  = 1'b0;
      assign dev_d_opcode[gi] = 3'd0;
      assign dev_d_size[gi]   = 2'd0;
      assign dev_d_source[gi] = 8'd0;
      assign dev_d_data[gi]   = 32'd0;
      assign dev_d_error[gi]  = 1'b0;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    case ({dev_req_fire, rsp_fire | tout_retire})
      2'b10:   cnt_d = cnt_q + CntW'(1);
      2'b01:   cnt_d = cnt_q - CntW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (dev_req_fire) state_d = ACTIVE;
               else if (sink_fire) state_d = ERR;
      ACTIVE:  if (tout_hit) state_d = TOUT;
               else if (cnt_d == '0) state_d = IDLE;
      ERR:     if (tl_h.d_ready) state_d = IDLE;
      TOUT:    if (tl_h.d_ready) state_d = (cnt_d == '0) ? IDLE : ACTIVE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      sel_q        <= '0;
      cap_source_q <= 8'd0;
      cap_size_q   <= 2'd0;
      cap_get_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (dev_req_fire) sel_q <= sel;
      // Last accepted request feeds both the error-sink and the timeout response.
      if (req_fire) begin
        cap_source_q <= tl_h.a_source;
        cap_size_q   <= tl_h.a_size;
        cap_get_q    <= (tl_h.a_opcode == 3'd4);
      end
    end
  end

`ifdef TLUL_SOCKET_TIMEOUT_EN
  localparam int TmrW = $clog2(TimeoutCyc);
  logic [TmrW-1:0] tmr_q;
  logic            timeout_q;

  assign tout_hit  = (state_q == ACTIVE) & ~rsp_fire & (tmr_q == TmrW'(TimeoutCyc - 1));
  assign timeout_o = timeout_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tmr_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (state_q == ACTIVE && !rsp_fire && !tout_hit) tmr_q <= tmr_q + TmrW'(1);
      else tmr_q <= '0;
      if (tout_retire) timeout_q <= 1'b1;
    end
  end
`else
  assign tout_hit  = 1'b0;
  assign timeout_o = 1'b0;
`endif
endmodule

// File: tb/tb_tlul_socket_1n_dec.sv
// Randomized self-checking bench for tlul_socket_1n_dec against a queue-based model of
// outstanding requests; timeout behaviour is modelled when TLUL_SOCKET_TIMEOUT_EN is defined.
module tb_tlul_socket_1n_dec;
  localparam int N  = 4;
  localparam int MO = 2;
  localparam int TO = 16;
  localparam logic [31:0] SPACE [N] = '{32'h1000, 32'h2000, 32'h3000, 32'h4000};
  localparam logic [31:0] MASKS [N] = '{default: 32'hFFF};

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic timeout;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  tlul_socket_1n_dec_if h_if ();
  tlul_socket_1n_dec_if d_if [N] ();

  tlul_socket_1n_dec #(
    .N(N), .AddrSpace(SPACE), .AddrMask(MASKS), .MaxOutst(MO), .TimeoutCyc(TO)
  ) dut (
    .clk_i(clk), .rst_i(rst), .tl_h(h_if), .tl_d(d_if), .timeout_o(timeout)
  );

  logic        dv_a_ready  [N];
  logic        dv_d_valid  [N];
  logic [31:0] dv_d_data   [N];
  logic [7:0]  dv_d_source [N];
  logic [2:0]  dv_d_opcode [N];
  logic        dv_d_error  [N];
  logic        dv_a_valid_o [N];
  logic        dv_d_ready_o [N];
  logic [31:0] dv_a_addr_o  [N];

  for (genvar gi = 0; gi < N; gi++) begin : g_dev
    assign d_if[gi].a_ready  = dv_a_ready[gi];
    assign d_if[gi].d_valid  = dv_d_valid[gi];
    assign d_if[gi].d_opcode = dv_d_opcode[gi];
    assign d_if[gi].d_size   = 2'd2;
    assign d_if[gi].d_source = dv_d_source[gi];
    assign d_if[gi].d_data   = dv_d_data[gi];
    assign d_if[gi].d_error  = dv_d_error[gi];
    assign dv_a_valid_o[gi]  = d_if[gi].a_valid;
    assign dv_d_ready_o[gi]  = d_if[gi].d_ready;
    assign dv_a_addr_o[gi]   = d_if[gi].a_address;
  end

  // Reference model: in-order queue of target devices plus pending error responses.
  int         outq[$];
  bit         err_act  = 0;
  bit         tout_act = 0;
  bit         tout_seen = 0;
  logic [7:0] last_src = 8'd0;
  bit         last_get = 0;
`ifdef TLUL_SOCKET_TIMEOUT_EN
  int         quiet = 0;
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int decode(input logic [31:0] a);
    for (int i = 0; i < N; i++)
      if (a >= SPACE[i] && a < SPACE[i] + 32'h1000) return i;
    return N;
  endfunction

  task automatic idle_inputs();
    h_if.a_valid = 1'b0; h_if.a_opcode = 3'd4; h_if.a_size = 2'd2; h_if.a_source = 8'd0;
    h_if.a_address = 32'd0; h_if.a_mask = 4'hF; h_if.a_data = 32'd0; h_if.d_ready = 1'b1;
    for (int k = 0; k < N; k++) begin
      dv_a_ready[k] = 1'b1; dv_d_valid[k] = 1'b0; dv_d_data[k] = 32'd0;
      dv_d_source[k] = 8'd0; dv_d_opcode[k] = 3'd1; dv_d_error[k] = 1'b0;
    end
  endtask

  task automatic host_req(input logic [31:0] addr, input logic [2:0] op, input logic [7:0] src);
    h_if.a_valid = 1'b1; h_if.a_address = addr; h_if.a_opcode = op; h_if.a_source = src;
  endtask

  task automatic rand_inputs();
    int b;
    h_if.a_valid = ($urandom_range(9) < 7);
    b = $urandom_range(5);
    h_if.a_address = ((b < 4) ? 32'h1000 * (b + 1) : ((b == 4) ? 32'h9000 : 32'h0))
                     | ($urandom & 32'hFFC);
    h_if.a_opcode = $urandom_range(1) ? 3'd4 : 3'd0;
    h_if.a_source = 8'($urandom);
    h_if.a_data   = $urandom;
    h_if.d_ready  = ($urandom_range(9) < 6);
    for (int k = 0; k < N; k++) begin
      dv_a_ready[k]  = ($urandom_range(3) != 0);
      dv_d_valid[k]  = ($urandom_range(9) < 4);
      dv_d_data[k]   = $urandom;
      dv_d_source[k] = 8'($urandom);
      dv_d_opcode[k] = 3'($urandom_range(1));
      dv_d_error[k]  = ($urandom_range(7) == 0);
    end
  endtask

  // One clock: check outputs at the falling edge, then advance the model to the next edge.
  task automatic step();
    int tgt, head;
    bit busy, allow, exp_ar, exp_dv, exp_dr, rsp, req;
    @(negedge clk);
    tgt   = decode(h_if.a_address);
    busy  = err_act || tout_act;
    head  = (outq.size() != 0) ? outq[0] : -1;
    allow = !busy && (outq.size() == 0 || (head == tgt && outq.size() < MO));
    exp_ar = allow && ((tgt == N) ? 1'b1 : dv_a_ready[tgt]);
    check("host_a_ready", h_if.a_ready, exp_ar);
    for (int k = 0; k < N; k++)
      check($sformatf("dev%0d_a_valid", k), dv_a_valid_o[k], h_if.a_valid && allow && tgt == k);
    if (allow && tgt < N) check("dev_a_address", dv_a_addr_o[tgt], h_if.a_address);
    exp_dv = busy ? 1'b1 : ((head >= 0) ? dv_d_valid[head] : 1'b0);
    check("host_d_valid", h_if.d_valid, exp_dv);
    if (busy) begin
      check("err_d_error", h_if.d_error, 1'b1);
      check("err_d_data", h_if.d_data, 32'hFFFF_FFFF);
      check("err_d_source", h_if.d_source, last_src);
      check("err_d_opcode", h_if.d_opcode, last_get ? 3'd1 : 3'd0);
    end else if (exp_dv) begin
      check("host_d_data", h_if.d_data, dv_d_data[head]);
      check("host_d_source", h_if.d_source, dv_d_source[head]);
      check("host_d_opcode", h_if.d_opcode, dv_d_opcode[head]);
      check("host_d_error", h_if.d_error, dv_d_error[head]);
    end
    for (int k = 0; k < N; k++) begin
      exp_dr = tout_act ? 1'b0 : ((head >= 0) ? (k == head && h_if.d_ready) : dv_d_valid[k]);
      check($sformatf("dev%0d_d_ready", k), dv_d_ready_o[k], exp_dr);
    end
    check("timeout_o", timeout, tout_seen);

    rsp = !busy && head >= 0 && dv_d_valid[head] && h_if.d_ready;
    req = h_if.a_valid && exp_ar;
`ifdef TLUL_SOCKET_TIMEOUT_EN
    if (tout_act) begin
      if (h_if.d_ready) begin
        void'(outq.pop_front());
        tout_act = 0; tout_seen = 1; quiet = 0;
        $display("TOUT_RSP src=%h", last_src);
      end
    end else if (!busy && head >= 0) begin
      if (rsp) quiet = 0;
      else if (quiet == TO - 1) begin tout_act = 1; quiet = 0; end
      else quiet++;
    end else quiet = 0;
`endif
    if (err_act && h_if.d_ready) begin
      err_act = 0;
      $display("ERR_RSP src=%h", last_src);
    end
    if (rsp) begin
      $display("RSP dev=%0d data=%h", head, dv_d_data[head]);
      void'(outq.pop_front());
    end
    if (req) begin
      last_src = h_if.a_source;
      last_get = (h_if.a_opcode == 3'd4);
      $display("REQ addr=%h tgt=%0d src=%h", h_if.a_address, tgt, h_if.a_source);
      if (tgt < N) outq.push_back(tgt);
      else err_act = 1;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    host_req(32'h1000, 3'd4, 8'd1);
    dv_d_valid[0] = 1'b1;
    #12;
    check("rst_a_ready", h_if.a_ready, 1'b0);
    check("rst_d_valid", h_if.d_valid, 1'b0);
    check("rst_timeout", timeout, 1'b0);
    for (int k = 0; k < N; k++) begin
      check("rst_dev_a_valid", dv_a_valid_o[k], 1'b0);
      check("rst_dev_d_ready", dv_d_ready_o[k], 1'b0);
    end
    idle_inputs();
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;

    // Get to dev1, then a one-cycle-later response with data 0xA5.
    host_req(32'h2004, 3'd4, 8'd3); step();
    idle_inputs(); dv_d_valid[1] = 1'b1; dv_d_data[1] = 32'hA5; step();
    idle_inputs(); step();

    // Three Gets to dev0 with no response: third stalls until one drains.
    host_req(32'h1000, 3'd4, 8'd7); dv_d_valid[0] = 1'b0;
    repeat (3) step();
    dv_d_valid[0] = 1'b1; step();
    h_if.a_valid = 1'b0; step(); step();
    idle_inputs();

    // Unmapped Get, source 5; response held while d_ready is low.
    host_req(32'h9000, 3'd4, 8'd5); step();
    idle_inputs(); h_if.d_ready = 1'b0; repeat (3) step();
    h_if.d_ready = 1'b1; step(); step();

`ifdef TLUL_SOCKET_TIMEOUT_EN
    host_req(32'h4000, 3'd4, 8'd9); step();
    idle_inputs(); repeat (20) step();
    dv_d_valid[3] = 1'b1; step(); idle_inputs(); step();
`endif

    repeat (400) begin rand_inputs(); step(); end

    // Same-cycle request and response on dev0, then reset mid-burst.
    idle_inputs(); step(); step(); step();
    host_req(32'h1000, 3'd0, 8'd2); dv_d_valid[0] = 1'b0; step();
    host_req(32'h1010, 3'd4, 8'd4); dv_d_valid[0] = 1'b1; step();
    #3 rst = 1'b1;
    #1;
    check("midrst_a_ready", h_if.a_ready, 1'b0);
    check("midrst_d_valid", h_if.d_valid, 1'b0);
    for (int k = 0; k < N; k++) begin
      check("midrst_dev_a_valid", dv_a_valid_o[k], 1'b0);
      check("midrst_dev_d_ready", dv_d_ready_o[k], 1'b0);
    end
    outq.delete();
    err_act = 0; tout_act = 0; tout_seen = 0;
`ifdef TLUL_SOCKET_TIMEOUT_EN
    quiet = 0;
`endif
    @(posedge clk);
    @(negedge clk) rst = 1'b0;
    idle_inputs(); dv_d_valid[0] = 1'b1;
    @(posedge clk); #1;
    step();
    repeat (200) begin rand_inputs(); step(); end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
